// File: rtl/otter_timer_pkg.sv
// otter_timer_pkg
//   Shared constants for the OTTER I/O-bus timer.
//   BASE_ADDR      : fixed word address of the register block
//   OFF_*          : byte offsets of each register from BASE_ADDR
//   CTRL_* / STATUS_PEND : bit positions inside CTRL and STATUS
//   reg_sel_e / decode() : exact word-address decode used by the top
package otter_timer_pkg;

    localparam logic [31:0] BASE_ADDR  = 32'h1100_0100;

    localparam logic [31:0] OFF_CTRL   = 32'h0000_0000;
    localparam logic [31:0] OFF_LOAD   = 32'h0000_0004;
    localparam logic [31:0] OFF_COUNT  = 32'h0000_0008;
    localparam logic [31:0] OFF_STATUS = 32'h0000_000C;
    localparam logic [31:0] OFF_PRESC  = 32'h0000_0010;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IE     = 2;
    localparam int STATUS_PEND = 0;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CTRL,
        REG_LOAD,
        REG_COUNT,
        REG_STATUS,
        REG_PRESC
    } reg_sel_e;

    // Full 32-bit compare: aliases and byte offsets inside a word hit nothing.
    function automatic reg_sel_e decode(input logic [31:0] addr);
        reg_sel_e sel;
        sel = REG_NONE;
        if      (addr == BASE_ADDR + OFF_CTRL)   sel = REG_CTRL;
        else if (addr == BASE_ADDR + OFF_LOAD)   sel = REG_LOAD;
        else if (addr == BASE_ADDR + OFF_COUNT)  sel = REG_COUNT;
        else if (addr == BASE_ADDR + OFF_STATUS) sel = REG_STATUS;
        else if (addr == BASE_ADDR + OFF_PRESC)  sel = REG_PRESC;
        return sel;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler
//   Divides CLK by presc+1 while enabled.
//   CLK   : clock
//   RST   : synchronous active-high reset
//   en    : count enable; counter frozen when low
//   clr   : synchronous clear of the counter (takes priority over counting)
//   presc : terminal value; tick fires when the counter equals it
//   tick  : one-cycle pulse, combinational from the counter state
module timer_prescaler (
    input  logic        CLK,
    input  logic        RST,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] presc,
    output logic        tick
);

    logic [15:0] cnt_q;

    assign tick = en && (cnt_q == presc);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            // If presc is lowered below the current count, the counter
            // runs through the 16-bit wrap and meets presc on the way back.
            cnt_q <= tick ? '0 : cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/otter_iobus_timer.sv
// otter_iobus_timer
//   Memory-mapped down-counting timer on the OTTER MCU I/O bus.
//   CLK        : clock
//   RST        : synchronous active-high reset
//   IOBUS_ADDR : MCU I/O address (exact word decode)
//   IOBUS_OUT  : MCU write data
//   IOBUS_WR   : one-cycle write strobe
//   IOBUS_IN   : zero-latency read data (0 while RST)
//   INT        : level interrupt, PEND & IE
module otter_iobus_timer
    import otter_timer_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        INT
);

    logic [2:0]  ctrl_q,  ctrl_d;
    logic [31:0] load_q,  load_d;
    logic [31:0] count_q, count_d;
    logic        pend_q,  pend_d;
    logic [15:0] presc_q, presc_d;

    reg_sel_e    sel;
    logic        wr_ctrl, wr_load, wr_status, wr_presc;
    logic        tick, psc_clr, expire, dec;
    logic [31:0] rdata;

    assign sel       = decode(IOBUS_ADDR);
    assign wr_ctrl   = IOBUS_WR && (sel == REG_CTRL);
    assign wr_load   = IOBUS_WR && (sel == REG_LOAD);
    assign wr_status = IOBUS_WR && (sel == REG_STATUS);
    assign wr_presc  = IOBUS_WR && (sel == REG_PRESC);

    // Restart the tick phase on a reload or when the timer is switched on.
    assign psc_clr = wr_load ||
                     (wr_ctrl && IOBUS_OUT[CTRL_EN] && !ctrl_q[CTRL_EN]);

    timer_prescaler u_psc (
        .CLK   (CLK),
        .RST   (RST),
        .en    (ctrl_q[CTRL_EN]),
        .clr   (psc_clr),
        .presc (presc_q),
        .tick  (tick)
    );

    // A LOAD write owns COUNT that cycle, so the tick is swallowed.
    assign expire = tick && !wr_load && (count_q == '0);
    assign dec    = tick && !wr_load && (count_q != '0);

    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        pend_d  = pend_q;
        presc_d = presc_q;

        if (wr_ctrl)  ctrl_d  = IOBUS_OUT[2:0];
        if (wr_load)  load_d  = IOBUS_OUT;
        if (wr_presc) presc_d = IOBUS_OUT[15:0];
        if (wr_status && IOBUS_OUT[STATUS_PEND]) pend_d = 1'b0;

        if (wr_load) begin
            count_d = IOBUS_OUT;
        end else if (dec) begin
            count_d = count_q - 32'd1;
        end else if (expire) begin
            count_d = ctrl_q[CTRL_AUTO] ? load_q : '0;
        end

        // Hardware events applied last so they win over software writes.
        if (expire) begin
            pend_d = 1'b1;
            if (!ctrl_q[CTRL_AUTO]) ctrl_d[CTRL_EN] = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
            presc_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            REG_CTRL:   rdata = {29'b0, ctrl_q};
            REG_LOAD:   rdata = load_q;
            REG_COUNT:  rdata = count_q;
            REG_STATUS: rdata = {31'b0, pend_q};
            REG_PRESC:  rdata = {16'b0, presc_q};
            default:    rdata = '0;
        endcase
    end

    // RST masks outputs so nothing leaks before the first reset edge.
    assign IOBUS_IN = RST ? '0 : rdata;
    assign INT      = !RST && pend_q && ctrl_q[CTRL_IE];

endmodule

// File: tb/tb_otter_iobus_timer.sv
module tb_otter_iobus_timer;

    localparam logic [31:0] B = 32'h1100_0100;
    localparam logic [31:0] A_CTRL = B, A_LOAD = B + 32'h4, A_COUNT = B + 32'h8;
    localparam logic [31:0] A_STAT = B + 32'hC, A_PRESC = B + 32'h10, A_UNMAP = B + 32'h14;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] IOBUS_ADDR = '0;
    logic [31:0] IOBUS_OUT = '0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] IOBUS_IN;
    logic        INT;

    otter_iobus_timer dut (
        .CLK        (CLK),
        .RST        (RST),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .INT        (INT)
    );

    always #5 CLK = ~CLK;

    int errs = 0, checks = 0, cyc = 0;
    logic [31:0] last_rd;
    logic        last_int;

    // Reference model: architectural register state plus a tick phase.
    bit          m_en, m_auto, m_ie, m_pend;
    logic [31:0] m_load, m_count;
    int          m_presc, m_pcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a);
        logic [31:0] p;
        p = m_presc;
        if (RST) return '0;
        if (a == A_CTRL)  return {29'b0, m_ie, m_auto, m_en};
        if (a == A_LOAD)  return m_load;
        if (a == A_COUNT) return m_count;
        if (a == A_STAT)  return {31'b0, m_pend};
        if (a == A_PRESC) return {16'b0, p[15:0]};
        return '0;
    endfunction

    task automatic m_step(input bit rst, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit tick, expire, old_auto, old_en;
        if (rst) begin
            m_en = 0; m_auto = 0; m_ie = 0; m_pend = 0;
            m_load = 0; m_count = 0; m_presc = 0; m_pcnt = 0;
            return;
        end
        tick     = m_en && (m_pcnt == m_presc);
        old_auto = m_auto;
        old_en   = m_en;
        expire   = 0;
        if (m_en) m_pcnt = tick ? 0 : ((m_pcnt + 1) % 65536);
        if (wr && a == A_LOAD) begin
            m_load = d; m_count = d; m_pcnt = 0;
        end else if (tick) begin
            if (m_count == 0) expire = 1;
            else m_count = m_count - 1;
        end
        if (wr && a == A_CTRL) begin
            m_en = d[0]; m_auto = d[1]; m_ie = d[2];
            if (d[0] && !old_en) m_pcnt = 0;
        end
        if (wr && a == A_STAT && d[0]) m_pend = 0;
        if (wr && a == A_PRESC) m_presc = int'(d[15:0]);
        if (expire) begin
            m_pend = 1;
            if (old_auto) m_count = m_load;
            else m_en = 0;
        end
    endtask

    // One bus cycle: drive, check the combinational read and INT, clock, step model.
    task automatic bus(input bit wr, input logic [31:0] a, input logic [31:0] d);
        IOBUS_WR = wr; IOBUS_ADDR = a; IOBUS_OUT = d;
        #1;
        last_rd  = IOBUS_IN;
        last_int = INT;
        chk("read", IOBUS_IN, mread(a));
        chk("int", {31'b0, INT}, {31'b0, (!RST && m_pend && m_ie)});
        @(posedge CLK);
        m_step(RST, wr, a, d);
        cyc++;
        #1;
        IOBUS_WR = 1'b0;
    endtask

    task automatic rd_exp(input string tag, input logic [31:0] a, input logic [31:0] exp, input int ei);
        bus(0, a, '0);
        chk(tag, last_rd, exp);
        if (ei >= 0) chk({tag, "_int"}, {31'b0, last_int}, ei);
    endtask

    task automatic wait_pend(output int t);
        t = -1;
        for (int i = 0; i < 100; i++) begin
            bus(0, A_STAT, '0);
            if (last_rd[0]) begin
                t = cyc - 1;
                return;
            end
        end
        checks++; errs++;
        $display("FAIL wait_pend: timeout, PEND never set");
    endtask

    task automatic idle_until(input int target);
        for (int i = 0; i < 200 && cyc < target; i++) bus(0, A_COUNT, '0);
    endtask

    int t1, t2;
    logic [31:0] a, d;

    initial begin
        @(posedge CLK);
        #1;
        // Reset: outputs masked while RST, all registers zero afterwards.
        bus(1, A_LOAD, 32'h1234);
        chk("rst_hold_rd", last_rd, 0);
        chk("rst_hold_int", {31'b0, last_int}, 0);
        RST = 1'b0;
        rd_exp("rst_ctrl", A_CTRL, 0, 0);
        rd_exp("rst_load", A_LOAD, 0, 0);
        rd_exp("rst_count", A_COUNT, 0, 0);
        rd_exp("rst_status", A_STAT, 0, 0);
        rd_exp("rst_presc", A_PRESC, 0, 0);

        // One-shot expiry.
        bus(1, A_PRESC, 0);
        bus(1, A_LOAD, 3);
        bus(1, A_CTRL, 5);
        rd_exp("os_cnt3", A_COUNT, 3, -1);
        rd_exp("os_cnt2", A_COUNT, 2, -1);
        rd_exp("os_cnt1", A_COUNT, 1, -1);
        rd_exp("os_cnt0", A_COUNT, 0, 0);
        rd_exp("os_pend", A_STAT, 1, 1);
        rd_exp("os_en_off", A_CTRL, 4, 1);
        bus(1, A_STAT, 1);
        rd_exp("os_clr", A_STAT, 0, 0);

        // Auto-reload with prescaler: period 6 cycles.
        bus(1, A_PRESC, 2);
        bus(1, A_LOAD, 1);
        bus(1, A_CTRL, 7);
        wait_pend(t1);
        bus(1, A_STAT, 1);
        wait_pend(t2);
        chk("auto_period", t2 - t1, 6);
        // W1C landing on an expiry edge: hardware set wins.
        idle_until(t2 + 5);
        bus(1, A_STAT, 1);
        rd_exp("w1c_collide", A_STAT, 1, 1);

        // LOAD write on an expiring tick: write wins, no expiry.
        bus(1, A_STAT, 1);
        idle_until(t2 + 11);
        bus(1, A_LOAD, 10);
        rd_exp("ld_collide_cnt", A_COUNT, 10, -1);
        rd_exp("ld_collide_pend", A_STAT, 0, 0);

        // Masking.
        bus(1, A_CTRL, 3);
        bus(1, A_STAT, 1);
        wait_pend(t1);
        chk("mask_int", {31'b0, last_int}, 0);
        bus(1, A_CTRL, 7);
        rd_exp("unmask_int", A_STAT, 1, 1);

        // Unmapped access.
        bus(1, A_CTRL, 0);
        bus(1, A_UNMAP, 32'hDEAD_BEEF);
        rd_exp("unmap_rd", A_UNMAP, 0, 0);
        rd_exp("unmap_ctrl", A_CTRL, 0, 0);
        rd_exp("unmap_load", A_LOAD, 10, -1);
        rd_exp("unmap_presc", A_PRESC, 2, -1);
        rd_exp("unmap_stat", A_STAT, 1, 0);
        rd_exp("unaligned", A_CTRL + 1, 0, -1);

        // Reset mid-count with a concurrent LOAD write.
        bus(1, A_PRESC, 0);
        bus(1, A_LOAD, 50);
        bus(1, A_CTRL, 5);
        idle_until(cyc + 4);
        RST = 1'b1;
        bus(1, A_LOAD, 7);
        RST = 1'b0;
        rd_exp("mid_rst_cnt", A_COUNT, 0, 0);
        rd_exp("mid_rst_load", A_LOAD, 0, -1);
        rd_exp("mid_rst_ctrl", A_CTRL, 0, -1);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 6))
                0: a = A_CTRL;
                1: a = A_LOAD;
                2: a = A_COUNT;
                3: a = A_STAT;
                4: a = A_PRESC;
                5: a = A_UNMAP;
                default: a = $urandom;
            endcase
            d = $urandom;
            if (a == A_LOAD)  d = $urandom_range(0, 6);
            if (a == A_PRESC) d[15:0] = 16'($urandom_range(0, 3));
            RST = ($urandom_range(0, 79) == 0);
            bus($urandom_range(0, 9) < 3, a, d);
        end
        RST = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/otter_iobus_timer.md
OTTER_IOBUS_TIMER -- requirements
Module: otter_iobus_timer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL have port CLK, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port IOBUS_ADDR, input, 32 bits: MCU I/O address.
REQ-005 SHALL have port IOBUS_OUT, input, 32 bits: MCU write data.
REQ-006 SHALL have port IOBUS_WR, input, 1 bit: MCU write strobe, one cycle per store.
REQ-007 SHALL have port IOBUS_IN, output, 32 bits: read data returned to the MCU.
REQ-008 SHALL have port INT, output, 1 bit: level interrupt request to the MCU.
REQ-009 SHALL fix BASE_ADDR at 32'h1100_0100 as a package constant, not a parameter.

Function
REQ-010 SHALL map registers as follows:
- CTRL at BASE+0x0, RW: bit0 EN, bit1 AUTO, bit2 IE.
- LOAD at BASE+0x4, RW, 32-bit.
- COUNT at BASE+0x8, RO.
- STATUS at BASE+0xC: bit0 PEND, write-1-to-clear.
- PRESC at BASE+0x10, RW, low 16 bits.
REQ-011 SHALL decode IOBUS_ADDR exactly on word addresses; unmapped addresses read 0, and writes to them are ignored.
REQ-012 SHALL drive IOBUS_IN combinationally from IOBUS_ADDR in the same cycle (zero-latency read); reads have no side effects.
REQ-013 SHALL apply a write at the rising edge where IOBUS_WR=1; the new value is visible on reads the following cycle.
REQ-014 SHALL read unused register bits as 0 and ignore writes to them.
REQ-015 SHALL load COUNT with the written value whenever LOAD is written.
REQ-016 SHALL also clear the prescaler counter whenever LOAD is written.
REQ-017 SHALL clear the prescaler counter whenever CTRL is written with EN transitioning 0->1.
REQ-018 SHALL generate a tick with EN=1 and a 16-bit prescaler counter:
- tick is asserted on the cycle the prescaler counter equals PRESC; the counter then returns to 0;
- otherwise the counter increments by 1;
- this gives one tick every PRESC+1 cycles.
REQ-019 SHALL hold the prescaler and COUNT frozen while EN=0.
REQ-020 SHALL decrement COUNT by 1 on a tick when COUNT!=0.
REQ-021 SHALL handle a tick with COUNT==0 (expiry) as follows:
- PEND<=1;
- if AUTO=1, COUNT<=LOAD;
- if AUTO=0, EN<=0 and COUNT stays 0.
REQ-022 SHALL expire on every tick when LOAD=0 and AUTO=1.
REQ-023 SHALL expire on the first tick when LOAD=0 and AUTO=0.
REQ-024 SHALL drive INT = PEND & IE, registered state only (no combinational path from the IOBUS inputs).
REQ-025 SHALL hold INT high until software clears PEND or clears IE.
REQ-026 SHALL give hardware set priority when a STATUS W1C and an expiry coincide: PEND stays 1.
REQ-027 SHALL give the software write priority when a LOAD write and a tick coincide: COUNT<=written value, and no decrement or expiry occurs that cycle.
REQ-028 SHALL give hardware priority when a CTRL write and an AUTO=0 expiry coincide: EN reads 0 afterward.
REQ-029 SHALL wrap COUNT only via reload; it never decrements below 0.
REQ-030 SHALL wrap the prescaler counter from PRESC to 0.

Reset
REQ-031 SHALL, when RST=1 at a rising edge, clear to 0 the following: CTRL, LOAD, COUNT, PEND, PRESC and the prescaler counter.
REQ-032 SHALL hold INT=0 while RST=1 and on the cycle after reset.
REQ-033 SHALL read IOBUS_IN as 0 for every address while RST=1.
REQ-034 SHALL give reset priority over any simultaneous IOBUS write or expiry, including when reset occurs mid-count.

Structure
REQ-035 SHALL place the following in a shared package otter_timer_pkg:
- BASE_ADDR;
- register offsets;
- CTRL bit indices (EN, AUTO, IE);
- STATUS bit index (PEND).
REQ-036 SHALL implement the prescaler as one sub-module, timer_prescaler, with inputs CLK, RST, en, clr, presc[15:0] and output tick.
REQ-037 SHALL keep all register state in the top module; read mux and address decode are combinational.

Verification
REQ-038 SHALL verify reset: assert RST one cycle, then read all five registers -> every read returns 0 and INT=0.
REQ-039 SHALL verify one-shot expiry:
- stimulus: PRESC=0, LOAD=3, CTRL=0x5;
- response: COUNT reads 3,2,1,0 on successive cycles; PEND=1 and INT=1 on the 5th cycle after the CTRL write; CTRL.EN then reads 0;
- then write STATUS=1 -> INT=0 the next cycle.
REQ-040 SHALL verify auto-reload with prescaler:
- stimulus: PRESC=2, LOAD=1, CTRL=0x7;
- response: PEND sets every 6 cycles;
- then clearing PEND in the same cycle as an expiry -> PEND remains 1.
REQ-041 SHALL verify LOAD-write collision: write LOAD=10 on a tick cycle -> COUNT reads 10 the next cycle, with no expiry.
REQ-042 SHALL verify masking: with IE=0, let the timer expire -> PEND=1 and INT=0; then write CTRL.IE=1 -> INT=1 the next cycle.
REQ-043 SHALL verify unmapped access: write 32'hDEAD_BEEF to BASE+0x14, then read it -> 0, and all other registers are unchanged.
